axi4s_pattern_gen: RTL and testbench

AXI4-stream master that generates programmable packet traffic for bring-up and debug of downstream stream slaves. It is the transmit-side counterpart of the stream debug monitor: it drives a configurable number of packets with a deterministic data pattern, honours backpressure, and keeps transfer and packet counters that a monitor on the same bus must match. It sits at the head of a stream pipeline in test builds, in place of the real source.

---
 rtl/axi4s_pkg.sv | 17 +
 rtl/axi4s_data_pattern.sv | 34 +++
 rtl/axi4s_pattern_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi4s_pattern_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_pkg.sv
// Shared constants for the AXI4-stream pattern generator.
package axi4s_pkg;

  // Data pattern selects
  localparam logic [1:0] PAT_INC   = 2'd0;
  localparam logic [1:0] PAT_CONST = 2'd1;
  localparam logic [1:0] PAT_INDEX = 2'd2;
  localparam logic [1:0] PAT_NINC  = 2'd3;

  // Generator FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/axi4s_data_pattern.sv
// Combinational data pattern for the next beat to be presented.
module axi4s_data_pattern
  import axi4s_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic [1:0]             pattern,
  input  logic [TDATA_WIDTH-1:0] seed,
  input  logic [TDATA_WIDTH-1:0] run_beat,
  input  logic [LEN_WIDTH-1:0]   pkt_idx,
  input  logic [LEN_WIDTH-1:0]   pkt_beat,
  output logic [TDATA_WIDTH-1:0] tdata_c
);

  localparam int unsigned HALF_WIDTH = TDATA_WIDTH / 2;

  logic [TDATA_WIDTH-1:0] inc_c;

  assign inc_c = seed + run_beat;

  // Select the pattern; index pattern packs {packet, beat} into halves
  always_comb begin
    tdata_c = inc_c;
    case (pattern)
      PAT_INC:   tdata_c = inc_c;
      PAT_CONST: tdata_c = seed;
      PAT_INDEX: tdata_c = {HALF_WIDTH'(pkt_idx), HALF_WIDTH'(pkt_beat)};
      PAT_NINC:  tdata_c = ~inc_c;
      default:   tdata_c = inc_c;
    endcase
  end

endmodule

// File: rtl/axi4s_pattern_gen.sv
// AXI4-stream master producing programmable packet traffic with counters.
module axi4s_pattern_gen
  import axi4s_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TUSER_WIDTH = 4,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                     axi4s_aclk,
  input  logic                     axi4s_aresetn,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic [LEN_WIDTH-1:0]     cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0]     cfg_pkt_count,
  input  logic [LEN_WIDTH-1:0]     cfg_gap,
  input  logic [1:0]               cfg_pattern,
  input  logic [TDATA_WIDTH-1:0]   cfg_seed,
  input  logic [TID_WIDTH-1:0]     cfg_tid,
  input  logic [TDEST_WIDTH-1:0]   cfg_tdest,
  output logic                     axi4s_tvalid,
  input  logic                     axi4s_tready,
  output logic [TDATA_WIDTH-1:0]   axi4s_tdata,
  output logic [TDATA_WIDTH/8-1:0] axi4s_tstrb,
  output logic [TDATA_WIDTH/8-1:0] axi4s_tkeep,
  output logic                     axi4s_tlast,
  output logic [TID_WIDTH-1:0]     axi4s_tid,
  output logic [TDEST_WIDTH-1:0]   axi4s_tdest,
  output logic [TUSER_WIDTH-1:0]   axi4s_tuser,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              beat_cnt,
  output logic [31:0]              pkt_cnt
);

  localparam int unsigned KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = 32;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d, count_q, count_d, gap_q, gap_d;
  logic [LEN_WIDTH-1:0]   gap_cnt_q, gap_cnt_d, beat_q, beat_d, pkt_q, pkt_d;
  logic [1:0]             pattern_q, pattern_d;
  logic [TDATA_WIDTH-1:0] seed_q, seed_d, run_beat_q, run_beat_d;
  logic                   stop_q, stop_d, busy_q, busy_d, done_q, done_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]  keep_q, keep_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic                   load_beat, end_run;

  logic                   idle_c, hs_c, last_c, count_hit_c;
  logic [1:0]             pattern_src_c;
  logic [TDATA_WIDTH-1:0] seed_src_c, next_tdata_c;
  logic [LEN_WIDTH-1:0]   cfg_len_eff_c, len_src_c;

  // In IDLE the first beat is built straight from the cfg inputs being latched
  assign idle_c        = (state_q == ST_IDLE);
  assign cfg_len_eff_c = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign pattern_src_c = idle_c ? cfg_pattern   : pattern_q;
  assign seed_src_c    = idle_c ? cfg_seed      : seed_q;
  assign len_src_c     = idle_c ? cfg_len_eff_c : len_q;
  assign last_c        = (beat_q == len_src_c - LEN_WIDTH'(1));
  assign hs_c          = tvalid_q & axi4s_tready;
  assign count_hit_c   = (count_q != '0) && (pkt_q == count_q);

  axi4s_data_pattern #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH)
  ) u_data_pattern (
    .pattern  (pattern_src_c),
    .seed     (seed_src_c),
    .run_beat (run_beat_q),
    .pkt_idx  (pkt_q),
    .pkt_beat (beat_q),
    .tdata_c  (next_tdata_c)
  );

  // Next-state, index and output-register logic
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    gap_d      = gap_q;
    pattern_d  = pattern_q;
    seed_d     = seed_q;
    tid_d      = tid_q;
    tdest_d    = tdest_q;
    gap_cnt_d  = gap_cnt_q;
    beat_d     = beat_q;
    pkt_d      = pkt_q;
    run_beat_d = run_beat_q;
    stop_d     = stop_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    load_beat  = 1'b0;
    end_run    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A start in the done cycle is deliberately ignored
        if (cfg_start && !done_q) begin
          state_d   = ST_SEND;
          busy_d    = 1'b1;
          stop_d    = 1'b0;
          len_d     = cfg_len_eff_c;
          count_d   = cfg_pkt_count;
          gap_d     = cfg_gap;
          pattern_d = cfg_pattern;
          seed_d    = cfg_seed;
          tid_d     = cfg_tid;
          tdest_d   = cfg_tdest;
          load_beat = 1'b1;
        end
      end
      ST_SEND: begin
        stop_d = stop_q | cfg_stop;
        if (hs_c) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          if (tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            if (count_hit_c || stop_d) begin
              end_run = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
            end else begin
              load_beat = 1'b1;
            end
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      ST_GAP: begin
        stop_d = stop_q | cfg_stop;
        if (gap_cnt_q > LEN_WIDTH'(1)) begin
          gap_cnt_d = gap_cnt_q - LEN_WIDTH'(1);
        end else if (stop_d) begin
          end_run = 1'b1;
        end else begin
          state_d   = ST_SEND;
          load_beat = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_beat) begin
      tvalid_d   = 1'b1;
      tdata_d    = next_tdata_c;
      tlast_d    = last_c;
      tuser_d    = TUSER_WIDTH'(beat_q == '0);
      run_beat_d = run_beat_q + TDATA_WIDTH'(1);
      if (last_c) begin
        beat_d = '0;
        pkt_d  = pkt_q + LEN_WIDTH'(1);
      end else begin
        beat_d = beat_q + LEN_WIDTH'(1);
      end
    end

    if (end_run) begin
      state_d    = ST_IDLE;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      stop_d     = 1'b0;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      tuser_d    = '0;
      beat_d     = '0;
      pkt_d      = '0;
      run_beat_d = '0;
    end

    keep_d = {KEEP_WIDTH{tvalid_d}};
  end

  // State and output registers
  always_ff @(posedge axi4s_aclk or negedge axi4s_aresetn) begin
    if (!axi4s_aresetn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      pattern_q  <= '0;
      seed_q     <= '0;
      tid_q      <= '0;
      tdest_q    <= '0;
      gap_cnt_q  <= '0;
      beat_q     <= '0;
      pkt_q      <= '0;
      run_beat_q <= '0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= '0;
      keep_q     <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      pattern_q  <= pattern_d;
      seed_q     <= seed_d;
      tid_q      <= tid_d;
      tdest_q    <= tdest_d;
      gap_cnt_q  <= gap_cnt_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
      run_beat_q <= run_beat_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      keep_q     <= keep_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign axi4s_tvalid = tvalid_q;
  assign axi4s_tdata  = tdata_q;
  assign axi4s_tstrb  = keep_q;
  assign axi4s_tkeep  = keep_q;
  assign axi4s_tlast  = tlast_q;
  assign axi4s_tid    = tid_q;
  assign axi4s_tdest  = tdest_q;
  assign axi4s_tuser  = tuser_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign beat_cnt     = beat_cnt_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_axi4s_pattern_gen.sv
// Self-checking bench for axi4s_pattern_gen: scoreboard of expected beats.
module tb_axi4s_pattern_gen;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          first;
  } beat_t;

  logic          axi4s_aclk;
  logic          axi4s_aresetn;
  logic          cfg_start, cfg_stop;
  logic [LW-1:0] cfg_pkt_len, cfg_pkt_count, cfg_gap;
  logic [1:0]    cfg_pattern;
  logic [DW-1:0] cfg_seed;
  logic [0:0]    cfg_tid;
  logic [3:0]    cfg_tdest;
  logic          axi4s_tvalid, axi4s_tready, axi4s_tlast;
  logic [DW-1:0] axi4s_tdata;
  logic [3:0]    axi4s_tstrb, axi4s_tkeep;
  logic [0:0]    axi4s_tid;
  logic [3:0]    axi4s_tdest, axi4s_tuser;
  logic          busy, done;
  logic [31:0]   beat_cnt, pkt_cnt;

  axi4s_pattern_gen #(
    .TDATA_WIDTH(32), .TID_WIDTH(1), .TDEST_WIDTH(4), .TUSER_WIDTH(4), .LEN_WIDTH(16)
  ) dut (
    .axi4s_aclk    (axi4s_aclk),
    .axi4s_aresetn (axi4s_aresetn),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_gap       (cfg_gap),
    .cfg_pattern   (cfg_pattern),
    .cfg_seed      (cfg_seed),
    .cfg_tid       (cfg_tid),
    .cfg_tdest     (cfg_tdest),
    .axi4s_tvalid  (axi4s_tvalid),
    .axi4s_tready  (axi4s_tready),
    .axi4s_tdata   (axi4s_tdata),
    .axi4s_tstrb   (axi4s_tstrb),
    .axi4s_tkeep   (axi4s_tkeep),
    .axi4s_tlast   (axi4s_tlast),
    .axi4s_tid     (axi4s_tid),
    .axi4s_tdest   (axi4s_tdest),
    .axi4s_tuser   (axi4s_tuser),
    .busy          (busy),
    .done          (done),
    .beat_cnt      (beat_cnt),
    .pkt_cnt       (pkt_cnt)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    hs_total = 0;
  int    hs_run   = 0;
  int    first_hs_cyc = 0;
  int    last_hs_cyc  = 0;
  int    exp_beats = 0;
  int    exp_pkts  = 0;
  int    gap_cur   = 0;
  int    gaps[$];
  beat_t exp_q[$];
  logic [0:0] exp_tid;
  logic [3:0] exp_tdest;

  initial begin
    axi4s_aclk = 1'b0;
    forever #5 axi4s_aclk = ~axi4s_aclk;
  end

  initial forever begin
    @(posedge axi4s_aclk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [1:0] pat, input logic [DW-1:0] seed,
                                             input int k, input int p, input int b);
    logic [31:0] pv, bv;
    pv = 32'(p);
    bv = 32'(b);
    case (pat)
      2'd0:    exp_data = seed + 32'(k);
      2'd1:    exp_data = seed;
      2'd2:    exp_data = {pv[15:0], bv[15:0]};
      default: exp_data = ~(seed + 32'(k));
    endcase
  endfunction

  task automatic push_run(input int len, input int count, input logic [1:0] pat, input logic [DW-1:0] seed);
    int    le;
    beat_t e;
    le = (len == 0) ? 1 : len;
    for (int p = 0; p < count; p++) begin
      for (int b = 0; b < le; b++) begin
        e.data  = exp_data(pat, seed, p * le + b, p, b);
        e.last  = (b == le - 1);
        e.first = (b == 0);
        exp_q.push_back(e);
        exp_beats++;
      end
    end
    exp_pkts += count;
  endtask

  task automatic start_run(input int len, input int count, input int gap, input logic [1:0] pat,
                           input logic [DW-1:0] seed, input logic [0:0] tid, input logic [3:0] tdest,
                           input logic with_stop);
    @(posedge axi4s_aclk); #1;
    cfg_pkt_len   = LW'(len);
    cfg_pkt_count = LW'(count);
    cfg_gap       = LW'(gap);
    cfg_pattern   = pat;
    cfg_seed      = seed;
    cfg_tid       = tid;
    cfg_tdest     = tdest;
    exp_tid       = tid;
    exp_tdest     = tdest;
    cfg_stop      = with_stop;
    cfg_start     = 1'b1;
    hs_run        = 0;
    gaps.delete();
    @(posedge axi4s_aclk); #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge axi4s_aclk); #1;
      if (rnd) axi4s_tready = 1'($urandom_range(0, 1));
      @(negedge axi4s_aclk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_done_after_last_hs"}, 64'(cyc), 64'(last_hs_cyc + 1));
      check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
      check({tag, "_tvalid_low_at_done"}, 64'(axi4s_tvalid), 64'd0);
    end
    axi4s_tready = 1'b1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(exp_beats));
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
    check({tag, "_beat_cnt_vs_hs"}, 64'(beat_cnt), 64'(hs_total));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Bus monitor: scoreboard pop on handshake, stall stability, gap lengths
  initial begin
    logic          stall_pend;
    logic [DW-1:0] st_data;
    logic          st_last;
    logic [3:0]    st_user;
    beat_t         e;
    stall_pend = 1'b0;
    st_data = '0;
    st_last = 1'b0;
    st_user = '0;
    forever begin
      @(negedge axi4s_aclk);
      if (axi4s_aresetn !== 1'b1) begin
        stall_pend = 1'b0;
        gap_cur = 0;
      end else begin
        if (stall_pend) begin
          check("stall_tvalid", 64'(axi4s_tvalid), 64'd1);
          check("stall_tdata", 64'(axi4s_tdata), 64'(st_data));
          check("stall_tlast", 64'(axi4s_tlast), 64'(st_last));
          check("stall_tuser", 64'(axi4s_tuser), 64'(st_user));
        end
        stall_pend = axi4s_tvalid && !axi4s_tready;
        st_data = axi4s_tdata;
        st_last = axi4s_tlast;
        st_user = axi4s_tuser;
        if (axi4s_tvalid && axi4s_tready) begin
          n_tests++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL extra_beat: observed data 0x%0h with empty scoreboard, expected no beat", axi4s_tdata);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_tdata", 64'(axi4s_tdata), 64'(e.data));
            check("beat_tlast", 64'(axi4s_tlast), 64'(e.last));
            check("beat_tuser", 64'(axi4s_tuser), 64'({3'b000, e.first}));
            check("beat_tkeep", 64'(axi4s_tkeep), 64'hF);
            check("beat_tstrb", 64'(axi4s_tstrb), 64'hF);
            check("beat_tid", 64'(axi4s_tid), 64'(exp_tid));
            check("beat_tdest", 64'(axi4s_tdest), 64'(exp_tdest));
          end
          hs_total++;
          hs_run++;
          if (hs_run == 1) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
        end
        if (busy && !axi4s_tvalid) begin
          gap_cur++;
        end else begin
          if (axi4s_tvalid && gap_cur != 0) gaps.push_back(gap_cur);
          gap_cur = 0;
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int starts;
    axi4s_aresetn = 1'b1;
    axi4s_tready  = 1'b1;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_pkt_len = '0;
    cfg_pkt_count = '0;
    cfg_gap = '0;
    cfg_pattern = '0;
    cfg_seed = '0;
    cfg_tid = '0;
    cfg_tdest = '0;
    exp_tid = '0;
    exp_tdest = '0;
    #3 axi4s_aresetn = 1'b0;
    repeat (3) @(posedge axi4s_aclk);
    #1 axi4s_aresetn = 1'b1;
    @(negedge axi4s_aclk);

    // Reset state
    check("rst_tvalid", 64'(axi4s_tvalid), 64'd0);
    check("rst_tkeep", 64'(axi4s_tkeep), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // 1: back-to-back incrementing pattern
    push_run(4, 2, 2'd0, 32'h10);
    start_run(4, 2, 0, 2'd0, 32'h10, 1'b1, 4'hA, 1'b0);
    @(negedge axi4s_aclk);
    check("t1_busy_with_tvalid", 64'(busy), 64'd1);
    check("t1_tvalid_rise", 64'(axi4s_tvalid), 64'd1);
    wait_done("t1", 100, 1'b0);
    check("t1_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd7);
    check_counters("t1");

    // 2: same run under random backpressure
    push_run(4, 2, 2'd0, 32'h10);
    start_run(4, 2, 0, 2'd0, 32'h10, 1'b1, 4'hA, 1'b0);
    wait_done("t2", 300, 1'b1);
    check_counters("t2");

    // 3: zero length, gaps, index pattern
    push_run(0, 3, 2'd2, 32'h1234);
    start_run(0, 3, 2, 2'd2, 32'h1234, 1'b0, 4'h3, 1'b0);
    wait_done("t3", 100, 1'b0);
    check_counters("t3");
    check("t3_gap_count", 64'(gaps.size()), 64'd2);
    if (gaps.size() == 2) begin
      check("t3_gap0", 64'(gaps[0]), 64'd2);
      check("t3_gap1", 64'(gaps[1]), 64'd2);
    end

    // 4: continuous run stopped during beat 2 of packet 5, seed wraps
    push_run(3, 5, 2'd0, 32'hFFFF_FFFE);
    start_run(3, 0, 0, 2'd0, 32'hFFFF_FFFE, 1'b0, 4'h6, 1'b0);
    starts = 0;
    for (int i = 0; i < 200 && starts < 5; i++) begin
      @(negedge axi4s_aclk);
      if (axi4s_tvalid && axi4s_tuser[0]) starts++;
    end
    check("t4_reach_pkt5", 64'(starts), 64'd5);
    @(posedge axi4s_aclk); #1 cfg_stop = 1'b1;
    @(posedge axi4s_aclk); #1 cfg_stop = 1'b0;
    wait_done("t4", 100, 1'b0);
    check_counters("t4");

    // 5: asynchronous reset mid-packet, then fresh run
    push_run(4, 2, 2'd0, 32'h100);
    start_run(4, 0, 0, 2'd0, 32'h100, 1'b1, 4'h3, 1'b0);
    repeat (5) @(posedge axi4s_aclk);
    #2 axi4s_aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", 64'(axi4s_tvalid), 64'd0);
    check("t5_rst_tdata", 64'(axi4s_tdata), 64'd0);
    check("t5_rst_tlast", 64'(axi4s_tlast), 64'd0);
    check("t5_rst_tuser", 64'(axi4s_tuser), 64'd0);
    check("t5_rst_tkeep", 64'(axi4s_tkeep), 64'd0);
    check("t5_rst_tid", 64'(axi4s_tid), 64'd0);
    check("t5_rst_tdest", 64'(axi4s_tdest), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    exp_q.delete();
    exp_beats = 0;
    exp_pkts = 0;
    hs_total = 0;
    repeat (2) @(posedge axi4s_aclk);
    #1 axi4s_aresetn = 1'b1;
    push_run(2, 1, 2'd0, 32'h55);
    start_run(2, 1, 0, 2'd0, 32'h55, 1'b0, 4'h1, 1'b0);
    wait_done("t5", 100, 1'b0);
    check_counters("t5");

    // 6: start+stop together, start and cfg changes mid-run, start in done cycle
    push_run(3, 2, 2'd3, 32'hA0);
    start_run(3, 2, 1, 2'd3, 32'hA0, 1'b0, 4'h5, 1'b1);
    @(posedge axi4s_aclk); #1;
    cfg_start     = 1'b1;
    cfg_pkt_len   = 16'd7;
    cfg_pkt_count = 16'd9;
    cfg_seed      = 32'h0;
    cfg_pattern   = 2'd1;
    cfg_tdest     = 4'h0;
    @(posedge axi4s_aclk); #1;
    cfg_start = 1'b0;
    wait_done("t6", 100, 1'b0);
    cfg_start = 1'b1;
    @(posedge axi4s_aclk); #1;
    cfg_start = 1'b0;
    @(negedge axi4s_aclk);
    check("t6_done_cycle_start_busy", 64'(busy), 64'd0);
    check("t6_done_cycle_start_tvalid", 64'(axi4s_tvalid), 64'd0);
    check("t6_done_single_pulse", 64'(done), 64'd0);
    check_counters("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
